// File: rtl/status_flag_unit.sv
// NZCV flag generation, architectural status register, forwarding to the
// condition checker, and in-flight flag-setter tracking with ID stall.
module status_flag_unit #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2,
    parameter int FWD_EN       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        flush,
    input  logic        exe_s,
    input  logic [31:0] exe_result,
    input  logic        exe_carry,
    input  logic        exe_overflow,
    input  logic        id_valid,
    input  logic        id_s,
    input  logic [3:0]  id_cond,
    input  logic        issue,
    output logic [3:0]  status_out,
    output logic [3:0]  status_fwd,
    output logic        flags_pending,
    output logic        cond_stall,
    output logic        pend_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [3:0]       COND_AL = 4'b1110;
    localparam logic [3:0]       COND_NV = 4'b1111;

    logic [3:0]       r_status;
    logic [CNT_W-1:0] r_count;
    logic             r_pend_err;

    logic [3:0]       w_new_flags;
    logic             w_inc;
    logic             w_dec;
    logic             w_underflow;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_fwd_dec;
    logic [CNT_W-1:0] w_eff;
    logic             w_is_cond;

    // Packed {Z,C,N,V}
    assign w_new_flags = {(exe_result == 32'd0), exe_carry, exe_result[31], exe_overflow};

    assign w_inc = issue & id_valid & id_s & ~flush;
    assign w_dec = exe_s;

    always_comb begin
        w_count_nxt = r_count;
        w_underflow = w_dec & ~w_inc & (r_count == '0);
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_inc && !w_dec) begin
            if (r_count != MAX_CNT) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end else if (!w_inc && w_dec) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status   <= 4'b0000;
            r_count    <= '0;
            r_pend_err <= 1'b0;
        end else if (!freeze) begin
            // EX is older than anything a flush kills, so its commit still lands.
            if (exe_s) begin
                r_status <= w_new_flags;
            end
            r_count <= w_count_nxt;
            if (w_underflow) begin
                r_pend_err <= 1'b1;
            end
        end
    end

    assign status_out    = r_status;
    assign status_fwd    = ((FWD_EN != 0) && exe_s) ? w_new_flags : r_status;
    assign flags_pending = (r_count != '0);
    assign pend_err      = r_pend_err;

    // The EX-stage setter resolves this cycle when it can be forwarded.
    assign w_fwd_dec = (FWD_EN != 0) & exe_s;
    assign w_eff     = (r_count == '0) ? '0 : r_count - CNT_W'(w_fwd_dec);
    assign w_is_cond = (id_cond != COND_AL) && (id_cond != COND_NV);

    assign cond_stall = id_valid & ((w_is_cond & (w_eff != '0)) |
                                    (id_s & (r_count == MAX_CNT) & ~exe_s));

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: forwarding and register-only variants
// driven side by side from the same stimulus.
module tb_status_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        flush;
    logic        exe_s;
    logic [31:0] exe_result;
    logic        exe_carry;
    logic        exe_overflow;
    logic        id_valid;
    logic        id_s;
    logic [3:0]  id_cond;
    logic        issue;

    logic [3:0]  status_out1, status_fwd1, status_out0, status_fwd0;
    logic        pending1, stall1, perr1, pending0, stall0, perr0;

    int errors = 0;
    int checks = 0;

    status_flag_unit #(.MAX_INFLIGHT(3), .CNT_W(2), .FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .exe_s(exe_s), .exe_result(exe_result), .exe_carry(exe_carry),
        .exe_overflow(exe_overflow), .id_valid(id_valid), .id_s(id_s),
        .id_cond(id_cond), .issue(issue),
        .status_out(status_out1), .status_fwd(status_fwd1),
        .flags_pending(pending1), .cond_stall(stall1), .pend_err(perr1)
    );

    status_flag_unit #(.MAX_INFLIGHT(3), .CNT_W(2), .FWD_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .exe_s(exe_s), .exe_result(exe_result), .exe_carry(exe_carry),
        .exe_overflow(exe_overflow), .id_valid(id_valid), .id_s(id_s),
        .id_cond(id_cond), .issue(issue),
        .status_out(status_out0), .status_fwd(status_fwd0),
        .flags_pending(pending0), .cond_stall(stall0), .pend_err(perr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        freeze = 0; flush = 0; exe_s = 0; exe_result = 32'h1;
        exe_carry = 0; exe_overflow = 0; id_valid = 0; id_s = 0;
        id_cond = 4'b1110; issue = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
    endtask

    // One flag-setting instruction leaves ID for EX.
    task automatic issue_adds();
        idle();
        id_valid = 1; id_s = 1; issue = 1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        checks++;
        if (status_out1 !== 4'b0000 || status_out0 !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b/%b exp 0000", status_out1, status_out0);
        end
        checks++;
        if (pending1 !== 1'b0 || perr1 !== 1'b0 || pending0 !== 1'b0 || perr0 !== 1'b0) begin
            errors++; $display("FAIL reset_flags: pending %b/%b err %b/%b exp 0", pending1, pending0, perr1, perr0);
        end
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic test_flag_gen();
        do_reset();
        issue_adds();
        issue_adds();
        exe_s = 1; exe_result = 32'h0; exe_carry = 1; exe_overflow = 0;
        #1;
        checks++;
        if (status_fwd1 !== 4'b1100) begin
            errors++; $display("FAIL fwd_zero_carry: got %b exp 1100", status_fwd1);
        end
        checks++;
        if (status_fwd0 !== 4'b0000) begin
            errors++; $display("FAIL nofwd_reads_reg: got %b exp 0000", status_fwd0);
        end
        step();
        checks++;
        if (status_out1 !== 4'b1100 || status_out0 !== 4'b1100) begin
            errors++; $display("FAIL status_zero_carry: got %b/%b exp 1100", status_out1, status_out0);
        end
        exe_s = 1; exe_result = 32'h8000_0000; exe_carry = 0; exe_overflow = 1;
        #1;
        checks++;
        if (status_fwd1 !== 4'b0011) begin
            errors++; $display("FAIL fwd_neg_ovf: got %b exp 0011", status_fwd1);
        end
        step();
        idle();
        checks++;
        if (status_out1 !== 4'b0011 || dut.r_count !== 2'd0 || perr1 !== 1'b0) begin
            errors++; $display("FAIL status_neg_ovf: status %b count %0d err %b exp 0011 0 0", status_out1, dut.r_count, perr1);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        issue_adds();
        id_valid = 1; id_s = 0; id_cond = 4'b0000; exe_s = 1; exe_result = 32'h7;
        #1;
        checks++;
        if (stall1 !== 1'b0) begin
            errors++; $display("FAIL hazard_fwd_stall: got %b exp 0", stall1);
        end
        checks++;
        if (stall0 !== 1'b1) begin
            errors++; $display("FAIL hazard_nofwd_stall: got %b exp 1", stall0);
        end
        step();
        exe_s = 0;
        #1;
        checks++;
        if (stall1 !== 1'b0 || stall0 !== 1'b0) begin
            errors++; $display("FAIL hazard_resolved: got %b/%b exp 0/0", stall1, stall0);
        end
        idle();
    endtask

    task automatic test_al_never();
        logic [3:0] conds [3] = '{4'b1110, 4'b1111, 4'b0000};
        logic       exp   [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        issue_adds();
        issue_adds();
        for (int i = 0; i < 3; i++) begin
            id_valid = 1; id_s = 0; id_cond = conds[i];
            #1;
            checks++;
            if (stall1 !== exp[i] || stall0 !== exp[i]) begin
                errors++; $display("FAIL cond_%b_stall: got %b/%b exp %b", conds[i], stall1, stall0, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        issue_adds();
        id_valid = 1; id_s = 1; issue = 1;
        exe_s = 1; exe_result = 32'h5; exe_carry = 1;
        step();
        idle();
        checks++;
        if (dut.r_count !== 2'd1 || status_out1 !== 4'b0100) begin
            errors++; $display("FAIL inc_dec_same: count %0d status %b exp 1 0100", dut.r_count, status_out1);
        end
        flush = 1; id_valid = 1; id_s = 1; issue = 1;
        exe_s = 1; exe_result = 32'h0;
        step();
        idle();
        checks++;
        if (dut.r_count !== 2'd0 || status_out1 !== 4'b1000 || perr1 !== 1'b0) begin
            errors++; $display("FAIL flush_commit: count %0d status %b err %b exp 0 1000 0", dut.r_count, status_out1, perr1);
        end
        issue_adds();
        freeze = 1; exe_s = 1; exe_result = 32'h8000_0000; exe_carry = 1; exe_overflow = 1;
        id_valid = 1; id_cond = 4'b0000;
        #1;
        checks++;
        if (stall0 !== 1'b1) begin
            errors++; $display("FAIL freeze_stall: got %b exp 1", stall0);
        end
        step();
        idle();
        checks++;
        if (dut.r_count !== 2'd1 || status_out1 !== 4'b1000 || status_out0 !== 4'b1000) begin
            errors++; $display("FAIL freeze_hold: count %0d status %b/%b exp 1 1000", dut.r_count, status_out1, status_out0);
        end
    endtask

    task automatic test_underflow_sat();
        do_reset();
        exe_s = 1; exe_result = 32'h1; exe_carry = 1;
        step();
        idle();
        checks++;
        if (perr1 !== 1'b1 || perr0 !== 1'b1 || pending1 !== 1'b0 || status_out1 !== 4'b0100) begin
            errors++; $display("FAIL underflow: err %b/%b pending %b status %b exp 1 1 0 0100", perr1, perr0, pending1, status_out1);
        end
        step();
        step();
        issue_adds();
        issue_adds();
        issue_adds();
        checks++;
        if (perr1 !== 1'b1 || dut.r_count !== 2'd3 || pending1 !== 1'b1) begin
            errors++; $display("FAIL sticky_and_fill: err %b count %0d pending %b exp 1 3 1", perr1, dut.r_count, pending1);
        end
        id_valid = 1; id_s = 1;
        #1;
        checks++;
        if (stall1 !== 1'b1 || stall0 !== 1'b1) begin
            errors++; $display("FAIL full_stall: got %b/%b exp 1", stall1, stall0);
        end
        issue = 1;
        step();
        idle();
        checks++;
        if (dut.r_count !== 2'd3 || dut0.r_count !== 2'd3) begin
            errors++; $display("FAIL saturate: got %0d/%0d exp 3", dut.r_count, dut0.r_count);
        end
        id_valid = 1; id_s = 1; exe_s = 1;
        #1;
        checks++;
        if (stall1 !== 1'b0 || stall0 !== 1'b0) begin
            errors++; $display("FAIL full_with_commit: got %b/%b exp 0", stall1, stall0);
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_adds();
        issue_adds();
        id_valid = 1; id_s = 1; issue = 1;
        exe_s = 1; exe_result = 32'h8000_0000; exe_carry = 1;
        step();
        idle();
        checks++;
        if (dut.r_count !== 2'd2 || status_out1 !== 4'b0110) begin
            errors++; $display("FAIL async_setup: count %0d status %b exp 2 0110", dut.r_count, status_out1);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (status_out1 !== 4'b0000 || pending1 !== 1'b0 || dut.r_count !== 2'd0) begin
            errors++; $display("FAIL async_reset: status %b pending %b count %0d exp 0000 0 0", status_out1, pending1, dut.r_count);
        end
        step();
        rst_n = 1;
        #1;
    endtask

    initial begin
        test_reset();
        test_flag_gen();
        test_hazard();
        test_al_never();
        test_simultaneous();
        test_underflow_sat();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within budget");
        $fatal(1);
    end

endmodule
